pattern_tx: RTL and testbench

- Serial pattern transmitter. Emits a programmable PAT_LEN-bit pattern MSB-first, one bit per clock, on a single-bit line.
- Repeats the pattern a programmable number of times back to back.
- It is the driving end of the serial sequence-detector interface. Its o output feeds a detector's i input directly, so it serves both as a bench stimulus source and as an on-chip test generator.

---
 rtl/pattern_tx.sv | 104 ++++++++++
 tb/tb_pattern_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter.
// Sends a latched PAT_LEN-bit pattern MSB-first, one bit per clock, repeated
// repeat_count times back to back. busy marks the bit window and done pulses
// once per request. All outputs are registered.
module pattern_tx #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]   repeat_count,
  output logic               o,
  output logic               busy,
  output logic               done
);

  localparam int BW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PAT_LEN-1:0] shreg;
  logic [PAT_LEN-1:0] pat_copy;
  logic [BW-1:0]      bit_cnt;
  logic [CNT_W-1:0]   rep_cnt;

  // Control FSM with shift register, counters and registered outputs.
  // o is loaded with the bit that will be visible next cycle, so the value
  // presented always matches the shift register position being consumed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      pat_copy <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      o        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          o    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            if (repeat_count != '0) begin
              shreg    <= pattern;
              pat_copy <= pattern;
              bit_cnt  <= BW'(PAT_LEN - 1);
              rep_cnt  <= repeat_count;
              o        <= pattern[PAT_LEN-1];
              busy     <= 1'b1;
              state    <= ST_SEND;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_SEND: begin
          if (bit_cnt != '0) begin
            shreg   <= shreg << 1;
            o       <= shreg[PAT_LEN-2];
            bit_cnt <= bit_cnt - BW'(1);
          end else if (rep_cnt > CNT_W'(1)) begin
            // Reload from the private copy so live input changes are ignored.
            shreg   <= pat_copy;
            o       <= pat_copy[PAT_LEN-1];
            bit_cnt <= BW'(PAT_LEN - 1);
            rep_cnt <= rep_cnt - CNT_W'(1);
          end else begin
            o     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          o     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          o     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Testbench for pattern_tx: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_pattern_tx;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   pattern = '0;
  logic [3:0]   repeat_count = '0;
  logic         o;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_tx #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .pattern(pattern),
    .repeat_count(repeat_count),
    .o(o),
    .busy(busy),
    .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request becomes a list of future {o,busy,done} values.
  logic [2:0] q[$];
  logic [2:0] cur = 3'b000;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q.delete();
      cur = 3'b000;
    end else begin
      if (q.size() == 0 && !cur[0] && start) begin
        for (int r = 0; r < int'(repeat_count); r++)
          for (int b = PAT_LEN - 1; b >= 0; b--)
            q.push_back({pattern[b], 2'b10});
        q.push_back(3'b001);
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = 3'b000;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (n_rst) check("cycle", {61'd0, o, busy, done}, {61'd0, cur});
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first idle cycle after done.
  task automatic xfer(input logic [3:0] p, input logic [3:0] rc,
                      output logic [63:0] bits, output int nbusy,
                      output int done_at, output int ndone);
    bits = '0; nbusy = 0; done_at = -1; ndone = 0;
    start = 1'b1; pattern = p; repeat_count = rc;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin bits = {bits[62:0], o}; nbusy++; end
      if (done) begin ndone++; if (done_at < 0) done_at = c; end
      if (done_at >= 0 && c >= done_at + 1) break;
    end
  endtask

  logic [63:0] bits;
  int nbusy, done_at, ndone;

  initial begin
    n_rst = 1'b0;
    idle(3);
    check("reset_o", {63'd0, o}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    n_rst = 1'b1;
    idle(2);

    // Single repetition of 1101
    xfer(4'b1101, 4'd1, bits, nbusy, done_at, ndone);
    check("t1_bits", bits, 64'b1101);
    check("t1_busy_cycles", 64'(nbusy), 64'd4);
    check("t1_done_cycle", 64'(done_at), 64'd5);
    check("t1_done_count", 64'(ndone), 64'd1);
    idle(2);

    // Three contiguous repetitions
    xfer(4'b1101, 4'd3, bits, nbusy, done_at, ndone);
    check("t2_bits", bits, 64'b110111011101);
    check("t2_busy_cycles", 64'(nbusy), 64'd12);
    check("t2_done_cycle", 64'(done_at), 64'd13);
    check("t2_done_count", 64'(ndone), 64'd1);
    idle(2);

    // Zero repetitions
    xfer(4'b1111, 4'd0, bits, nbusy, done_at, ndone);
    check("t3_busy_cycles", 64'(nbusy), 64'd0);
    check("t3_done_cycle", 64'(done_at), 64'd1);
    check("t3_done_count", 64'(ndone), 64'd1);
    idle(2);

    // Input changes while busy, start held through DONE
    begin
      logic [7:0] b8;
      int nd, da, got_done;
      b8 = '0; nd = 0; da = -1;
      start = 1'b1; pattern = 4'b1010; repeat_count = 4'd2;
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        if (c <= 8) b8 = {b8[6:0], o};
        if (done) begin nd++; if (da < 0) da = c; end
        if (c == 1) start = 1'b0;
        if (c == 2) start = 1'b1;
        if (c == 3) begin pattern = 4'b0110; start = 1'b0; end
        if (c == 7) start = 1'b1;
        if (c == 10) check("t4_idle_gap_busy", {63'd0, busy}, 64'd0);
        if (c == 11) begin check("t4_restart_busy", {63'd0, busy}, 64'd1); start = 1'b0; end
      end
      check("t4_bits", {56'd0, b8}, 64'b10101010);
      check("t4_done_cycle", 64'(da), 64'd9);
      check("t4_done_count", 64'(nd), 64'd1);
      got_done = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (done) begin got_done = 1; break; end
      end
      check("t4_second_done", 64'(got_done), 64'd1);
      idle(2);
    end

    // Asynchronous reset mid-transfer
    begin
      int nd;
      nd = 0;
      start = 1'b1; pattern = 4'b1111; repeat_count = 4'd15;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        start = 1'b0;
      end
      check("t5_busy_before_reset", {63'd0, busy}, 64'd1);
      #2 n_rst = 1'b0;
      #1;
      check("t5_o_async", {63'd0, o}, 64'd0);
      check("t5_busy_async", {63'd0, busy}, 64'd0);
      idle(2);
      n_rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done) nd++;
      end
      check("t5_no_done", 64'(nd), 64'd0);
      xfer(4'b0001, 4'd1, bits, nbusy, done_at, ndone);
      check("t5_bits", bits, 64'b0001);
      check("t5_done_cycle", 64'(done_at), 64'd5);
      idle(2);
    end

    // Back-to-back: second start on the first idle cycle after done
    xfer(4'b1101, 4'd1, bits, nbusy, done_at, ndone);
    check("t6_gap_busy", {63'd0, busy}, 64'd0);
    check("t6_gap_o", {63'd0, o}, 64'd0);
    xfer(4'b1001, 4'd2, bits, nbusy, done_at, ndone);
    check("t6_bits", bits, 64'b10011001);
    check("t6_busy_cycles", 64'(nbusy), 64'd8);
    check("t6_done_cycle", 64'(done_at), 64'd9);
    idle(2);

    // Randomized traffic, including input churn and occasional resets
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      pattern = 4'($urandom);
      repeat_count = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        #3 n_rst = 1'b0;
        #1;
        check("rand_async_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
      end
    end
    start = 1'b0;
    idle(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
